victim_cache_param: RTL and testbench
=====================================

VICTIM_CACHE_PARAM -- requirements
Module: victim_cache_param

Interface
REQ-001 SHALL have parameter NUM_LINES, default 8, fully-associative line count; power of 2, >=2.
REQ-002 SHALL have parameter ADDR_WIDTH, default 13, line address width (unit = cache line).
REQ-003 SHALL have parameter DATA_WIDTH, default 64, line data width.
REQ-004 SHALL have parameter WB_DEPTH, default 4, writeback FIFO depth; >=1.
REQ-005 SHALL have ports, one per line:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- rd_valid  in  1  lookup request.
- rd_addr  in  ADDR_WIDTH  lookup address.
- rd_take  in  1  invalidate line on hit (swap-out to L1).
- rd_hit  out  1  lookup hit, combinational.
- rd_data  out  DATA_WIDTH  hit line data; 0 on miss.
- rd_dirty  out  1  hit line dirty bit; 0 on miss.
- ins_valid  in  1  insert request.
- ins_ready  out  1  insert accepted this cycle.
- ins_addr  in  ADDR_WIDTH  insert address.
- ins_data  in  DATA_WIDTH  insert data.
- ins_dirty  in  1  insert dirty flag.
- wb_valid  out  1  writeback FIFO head valid.
- wb_ready  in  1  downstream accepts head.
- wb_addr  out  ADDR_WIDTH  head address.
- wb_data  out  DATA_WIDTH  head data.
- flush_req  in  1  start flush (pulse).
- flush_busy  out  1  flush in progress.
- occupancy  out  clog2(NUM_LINES+1)  count of valid lines.

Function
REQ-006 SHALL compute rd_hit = rd_valid & !flush_busy & (exactly one valid line address-matches rd_addr), same cycle.
REQ-007 SHALL, on rd_hit & rd_take, invalidate the hit line at the next edge with no PLRU update; rd_hit & !rd_take SHALL touch the line in PLRU.
REQ-008 SHALL drive ins_ready = !flush_busy & (FIFO count < WB_DEPTH), independent of ins_dirty or hit status.
REQ-009 SHALL, on insert handshake with address hit: overwrite data, dirty = old | ins_dirty, touch PLRU, no eviction.
REQ-010 SHALL, on insert miss: victim = lowest-index invalid line; if none, PLRU victim; write addr/data/dirty, set valid, touch PLRU.
REQ-011 SHALL push {victim addr, data} into FIFO at the same edge when the evicted line was valid & dirty; clean victims discarded.
REQ-012 SHALL use tree PLRU, NUM_LINES-1 bits; node bit 0 = victim in lower-index subtree; touch sets path bits to point away from touched line; all-zero selects line 0.
REQ-013 SHALL resolve victim selection from pre-edge state; when read and insert target the same line in one cycle, insert wins (line valid with insert data); PLRU applies read touch then insert touch.
REQ-014 SHALL implement FIFO with push/pop in same cycle allowed; wb_valid = not empty; wb_addr/wb_data from registered head; pop on wb_valid & wb_ready.
REQ-015 SHALL implement FSM IDLE, FLUSH, DRAIN: IDLE->FLUSH on flush_req (ignored when busy); FLUSH scans index 0..NUM_LINES-1, one line per cycle, pushing valid & dirty lines, invalidating all; scan holds while FIFO full; after last index ->DRAIN; DRAIN->IDLE when FIFO empty.
REQ-016 SHALL assert flush_busy in FLUSH and DRAIN; a handshake in the cycle flush_req is sampled completes first.
REQ-017 SHALL update occupancy registered, reflecting all edge changes (insert, take, flush).
REQ-018 SHALL keep FIFO pops active during FLUSH/DRAIN.

Reset
REQ-019 SHALL on rst: all lines invalid/clean, PLRU bits 0, FIFO empty, FSM IDLE; rd_hit 0, rd_data 0, ins_ready 1, wb_valid 0, flush_busy 0, occupancy 0; rst mid-flush aborts with no further pushes.

Verification (NUM_LINES=4, WB_DEPTH=2)
REQ-020 Insert 0x10..0x13 clean, read 0x10 (no take), insert 0x20 -> line 2 (0x12) replaced, no wb_valid, occupancy 4.
REQ-021 Fill with dirty lines, wb_ready=0, insert two misses -> two wb pushes, ins_ready 0 afterwards; release wb_ready -> ins_ready 1 after one pop.
REQ-022 Insert 0x30 clean then 0x30 dirty data 0xAA -> hit, rd_data 0xAA, rd_dirty 1, occupancy unchanged.
REQ-023 Read 0x11 with rd_take -> rd_hit 1 that cycle, next cycle rd_hit 0, occupancy decrements; next insert miss uses that slot.
REQ-024 Three dirty lines, wb_ready=0, flush_req -> flush_busy 1, scan stalls at full FIFO, resumes on wb_ready=1; ends occupancy 0, three wb beats, flush_busy 0.

Source files
------------

// File: rtl/victim_cache_param.sv
// Fully-associative victim cache with tree-PLRU replacement,
// a writeback FIFO for dirty evictions and a scan-based flush.
module victim_cache_param #(
  parameter int NUM_LINES  = 8,
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 64,
  parameter int WB_DEPTH   = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               rd_valid,
  input  logic [ADDR_WIDTH-1:0]              rd_addr,
  input  logic                               rd_take,
  output logic                               rd_hit,
  output logic [DATA_WIDTH-1:0]              rd_data,
  output logic                               rd_dirty,
  input  logic                               ins_valid,
  output logic                               ins_ready,
  input  logic [ADDR_WIDTH-1:0]              ins_addr,
  input  logic [DATA_WIDTH-1:0]              ins_data,
  input  logic                               ins_dirty,
  output logic                               wb_valid,
  input  logic                               wb_ready,
  output logic [ADDR_WIDTH-1:0]              wb_addr,
  output logic [DATA_WIDTH-1:0]              wb_data,
  input  logic                               flush_req,
  output logic                               flush_busy,
  output logic [$clog2(NUM_LINES+1)-1:0]     occupancy
);
  localparam int LG = $clog2(NUM_LINES);
  localparam int OW = $clog2(NUM_LINES + 1);
  localparam int PW = (WB_DEPTH > 1) ? $clog2(WB_DEPTH) : 1;
  localparam int CW = $clog2(WB_DEPTH + 1);

  typedef enum logic [1:0] {IDLE, FLUSH, DRAIN} state_t;

  state_t                state, state_n;
  logic [NUM_LINES-1:0]  valid, valid_n, dirty, dirty_n;
  logic [ADDR_WIDTH-1:0] tag [NUM_LINES];
  logic [ADDR_WIDTH-1:0] tag_n [NUM_LINES];
  logic [DATA_WIDTH-1:0] line [NUM_LINES];
  logic [DATA_WIDTH-1:0] line_n [NUM_LINES];
  logic [NUM_LINES-2:0]  plru, plru_n;
  logic [LG-1:0]         scan, scan_n;

  logic [ADDR_WIDTH-1:0] fa [WB_DEPTH];
  logic [DATA_WIDTH-1:0] fd [WB_DEPTH];
  logic [PW-1:0]         head, tail;
  logic [CW-1:0]         count;
  logic                  push, pop;
  logic [ADDR_WIDTH-1:0] push_addr;
  logic [DATA_WIDTH-1:0] push_data;

  logic [NUM_LINES-1:0]  rmatch, imatch;
  logic [LG-1:0]         ridx, iidx, vict, slot;
  logic                  ins_fire, ins_hit;

  function automatic logic [LG-1:0] first_set(input logic [NUM_LINES-1:0] v);
    first_set = '0;
    for (int i = NUM_LINES - 1; i >= 0; i--)
      if (v[i]) first_set = LG'(i);
  endfunction

  function automatic logic [LG-1:0] plru_victim(input logic [NUM_LINES-2:0] t);
    int n;
    n = 0;
    for (int l = 0; l < LG; l++)
      n = 2 * n + 1 + int'(t[n]);
    return LG'(n - (NUM_LINES - 1));
  endfunction

  // Each node on the path is pointed at the sibling subtree.
  function automatic logic [NUM_LINES-2:0] plru_touch(
    input logic [NUM_LINES-2:0] t,
    input logic [LG-1:0]        w
  );
    int   n;
    logic d;
    n = 0;
    plru_touch = t;
    for (int l = 0; l < LG; l++) begin
      d = w[LG-1-l];
      plru_touch[n] = ~d;
      n = 2 * n + 1 + int'(d);
    end
  endfunction

  always_comb begin
    for (int i = 0; i < NUM_LINES; i++) begin
      rmatch[i] = valid[i] && (tag[i] == rd_addr);
      imatch[i] = valid[i] && (tag[i] == ins_addr);
    end
  end

  assign flush_busy = (state != IDLE);
  assign ridx       = first_set(rmatch);
  assign rd_hit     = rd_valid && !flush_busy && $onehot(rmatch);
  assign rd_data    = rd_hit ? line[ridx] : '0;
  assign rd_dirty   = rd_hit && dirty[ridx];

  assign ins_ready = !flush_busy && (count < CW'(WB_DEPTH));
  assign ins_fire  = ins_valid && ins_ready;
  assign ins_hit   = |imatch;
  assign iidx      = first_set(imatch);
  assign vict      = (&valid) ? plru_victim(plru) : first_set(~valid);
  assign slot      = ins_hit ? iidx : vict;

  assign wb_valid = (count != '0);
  assign wb_addr  = fa[head];
  assign wb_data  = fd[head];
  assign pop      = wb_valid && wb_ready;

  always_comb begin
    valid_n   = valid;
    dirty_n   = dirty;
    tag_n     = tag;
    line_n    = line;
    plru_n    = plru;
    state_n   = state;
    scan_n    = scan;
    push      = 1'b0;
    push_addr = tag[vict];
    push_data = line[vict];
    if (rd_hit && rd_take) begin
      valid_n[ridx] = 1'b0;
      dirty_n[ridx] = 1'b0;
    end
    if (rd_hit && !rd_take)
      plru_n = plru_touch(plru_n, ridx);
    // Insert is applied after the read so it wins on a shared line.
    if (ins_fire) begin
      valid_n[slot] = 1'b1;
      dirty_n[slot] = (ins_hit && dirty[slot]) || ins_dirty;
      tag_n[slot]   = ins_addr;
      line_n[slot]  = ins_data;
      plru_n        = plru_touch(plru_n, slot);
      push          = !ins_hit && valid[vict] && dirty[vict];
    end
    unique case (state)
      IDLE: begin
        if (flush_req) begin
          state_n = FLUSH;
          scan_n  = '0;
        end
      end
      FLUSH: begin
        if (count < CW'(WB_DEPTH)) begin
          push          = valid[scan] && dirty[scan];
          push_addr     = tag[scan];
          push_data     = line[scan];
          valid_n[scan] = 1'b0;
          dirty_n[scan] = 1'b0;
          if (scan == LG'(NUM_LINES - 1)) state_n = DRAIN;
          else scan_n = scan + LG'(1);
        end
      end
      DRAIN: begin
        if (count == '0) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid     <= '0;
      dirty     <= '0;
      plru      <= '0;
      state     <= IDLE;
      scan      <= '0;
      occupancy <= '0;
    end else begin
      valid     <= valid_n;
      dirty     <= dirty_n;
      plru      <= plru_n;
      state     <= state_n;
      scan      <= scan_n;
      occupancy <= OW'($countones(valid_n));
    end
  end

  always_ff @(posedge clk) begin
    tag  <= tag_n;
    line <= line_n;
  end

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(WB_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        fa[tail] <= push_addr;
        fd[tail] <= push_data;
        tail     <= ptr_inc(tail);
      end
      if (pop) head <= ptr_inc(head);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: tb/tb_victim_cache_param.sv
// Bench for victim_cache_param: directed scenarios plus random traffic,
// all outputs compared each cycle against a line/queue level model.
module tb_victim_cache_param;
  localparam int N  = 4;
  localparam int AW = 8;
  localparam int DW = 16;
  localparam int WD = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          rd_valid, rd_take, rd_hit, rd_dirty;
  logic [AW-1:0] rd_addr, ins_addr, wb_addr;
  logic [DW-1:0] rd_data, ins_data, wb_data;
  logic          ins_valid, ins_ready, ins_dirty;
  logic          wb_valid, wb_ready, flush_req, flush_busy;
  logic [2:0]    occupancy;

  always #5 clk = ~clk;

  victim_cache_param #(
    .NUM_LINES(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WB_DEPTH(WD)
  ) dut (
    .clk(clk), .rst(rst),
    .rd_valid(rd_valid), .rd_addr(rd_addr), .rd_take(rd_take),
    .rd_hit(rd_hit), .rd_data(rd_data), .rd_dirty(rd_dirty),
    .ins_valid(ins_valid), .ins_ready(ins_ready), .ins_addr(ins_addr),
    .ins_data(ins_data), .ins_dirty(ins_dirty),
    .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_addr(wb_addr), .wb_data(wb_data),
    .flush_req(flush_req), .flush_busy(flush_busy), .occupancy(occupancy)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference state: lines, PLRU tree bits, FIFO queue, flush phase.
  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wb_t;

  bit            mv [N];
  bit            md [N];
  logic [AW-1:0] ma [N];
  logic [DW-1:0] mdat [N];
  bit            pl [N-1];
  int            mst, mscan;
  wb_t           q[$];

  task automatic reset_model();
    for (int i = 0; i < N; i++) begin
      mv[i] = 0;
      md[i] = 0;
    end
    for (int i = 0; i < N - 1; i++) pl[i] = 0;
    mst = 0;
    mscan = 0;
    q.delete();
  endtask

  // Walk ranges: a node bit of 1 means the victim lies in the upper half.
  function automatic int m_victim();
    int lo, sz, node;
    lo = 0; sz = N; node = 0;
    while (sz > 1) begin
      if (pl[node]) begin
        lo += sz / 2;
        node = 2 * node + 2;
      end else begin
        node = 2 * node + 1;
      end
      sz /= 2;
    end
    return lo;
  endfunction

  task automatic m_touch(input int ln);
    int lo, sz, node;
    lo = 0; sz = N; node = 0;
    while (sz > 1) begin
      if (ln < lo + sz / 2) begin
        pl[node] = 1;
        node = 2 * node + 1;
      end else begin
        pl[node] = 0;
        lo += sz / 2;
        node = 2 * node + 2;
      end
      sz /= 2;
    end
  endtask

  task automatic step();
    int  n, hidx, slot, vic, presz, occ;
    bit  hit, busy, rdy, ihit;
    bit  pv [N];
    bit  pd [N];
    busy  = (mst != 0);
    presz = q.size();
    n = 0; hidx = 0; occ = 0;
    for (int i = 0; i < N; i++) begin
      if (mv[i] && ma[i] == rd_addr) begin
        n++;
        hidx = i;
      end
      if (mv[i]) occ++;
    end
    hit = rd_valid && !busy && n == 1;
    rdy = !busy && presz < WD;
    chk("rd_hit", rd_hit, hit);
    chk("rd_data", rd_data, hit ? mdat[hidx] : '0);
    chk("rd_dirty", rd_dirty, hit ? md[hidx] : 1'b0);
    chk("ins_ready", ins_ready, rdy);
    chk("wb_valid", wb_valid, presz != 0);
    if (presz != 0) begin
      chk("wb_addr", wb_addr, q[0].a);
      chk("wb_data", wb_data, q[0].d);
    end
    chk("flush_busy", flush_busy, busy);
    chk("occupancy", occupancy, occ);
    if (rst) begin
      reset_model();
      return;
    end
    pv = mv;
    pd = md;
    vic = m_victim();
    if (presz != 0 && wb_ready) void'(q.pop_front());
    if (hit && rd_take) begin
      mv[hidx] = 0;
      md[hidx] = 0;
    end else if (hit) begin
      m_touch(hidx);
    end
    if (ins_valid && rdy) begin
      ihit = 0; slot = 0;
      for (int i = 0; i < N; i++)
        if (pv[i] && ma[i] == ins_addr) begin
          ihit = 1;
          slot = i;
        end
      if (!ihit) begin
        slot = -1;
        for (int i = N - 1; i >= 0; i--) if (!pv[i]) slot = i;
        if (slot < 0) slot = vic;
        if (pv[slot] && pd[slot]) q.push_back('{ma[slot], mdat[slot]});
      end
      mv[slot]   = 1;
      md[slot]   = (ihit && pd[slot]) || ins_dirty;
      ma[slot]   = ins_addr;
      mdat[slot] = ins_data;
      m_touch(slot);
    end
    case (mst)
      0: if (flush_req) begin
        mst = 1;
        mscan = 0;
      end
      1: if (presz < WD) begin
        if (pv[mscan] && pd[mscan]) q.push_back('{ma[mscan], mdat[mscan]});
        mv[mscan] = 0;
        md[mscan] = 0;
        if (mscan == N - 1) mst = 2;
        else mscan++;
      end
      default: if (presz == 0) mst = 0;
    endcase
  endtask

  // Entered at a negedge with inputs set; checks, then waits for next negedge.
  task automatic tick();
    #1 step();
    @(negedge clk);
  endtask

  task automatic quiet();
    rst = 0; rd_valid = 0; rd_take = 0; rd_addr = '0;
    ins_valid = 0; ins_addr = '0; ins_data = '0; ins_dirty = 0;
    flush_req = 0;
  endtask

  task automatic hard_reset();
    quiet();
    rst = 1;
    @(negedge clk);
    @(negedge clk);
    rst = 0;
    reset_model();
  endtask

  task automatic ins(input logic [AW-1:0] a, input logic [DW-1:0] d,
                     input bit dt);
    ins_valid = 1; ins_addr = a; ins_data = d; ins_dirty = dt;
    tick();
    quiet();
  endtask

  task automatic rd(input logic [AW-1:0] a, input bit tk);
    rd_valid = 1; rd_addr = a; rd_take = tk;
    tick();
    quiet();
  endtask

  int beats;

  initial begin
    wb_ready = 1;
    quiet();
    @(negedge clk);
    hard_reset();
    chk("rst_occ", occupancy, 0);
    chk("rst_ready", ins_ready, 1);
    chk("rst_wb", wb_valid, 0);
    chk("rst_busy", flush_busy, 0);

    for (int i = 0; i < 4; i++) ins(AW'(8'h10 + i), DW'(16'h100 + i), 0);
    rd(8'h10, 0);
    ins(8'h20, 16'h0200, 0);
    chk("r20_occ", occupancy, 4);
    chk("r20_wb", wb_valid, 0);
    rd_valid = 1; rd_addr = 8'h12;
    #1 chk("r20_gone", rd_hit, 0);
    tick();
    rd_addr = 8'h20;
    #1 chk("r20_new", rd_hit, 1);
    tick();
    quiet();

    hard_reset();
    wb_ready = 0;
    for (int i = 0; i < 4; i++) ins(AW'(8'h40 + i), DW'(16'h400 + i), 1);
    ins(8'h50, 16'h0500, 1);
    ins(8'h51, 16'h0501, 1);
    chk("r21_full", ins_ready, 0);
    chk("r21_wb", wb_valid, 1);
    wb_ready = 1;
    tick();
    chk("r21_ready", ins_ready, 1);
    repeat (2) tick();

    hard_reset();
    ins(8'h30, 16'h0011, 0);
    ins(8'h30, 16'h00AA, 1);
    rd_valid = 1; rd_addr = 8'h30;
    #1 chk("r22_data", rd_data, 16'h00AA);
    chk("r22_dirty", rd_dirty, 1);
    chk("r22_occ", occupancy, 1);
    tick();
    quiet();

    hard_reset();
    for (int i = 0; i < 3; i++) ins(AW'(8'h10 + i), DW'(16'h700 + i), 0);
    rd_valid = 1; rd_addr = 8'h11; rd_take = 1;
    #1 chk("r23_hit", rd_hit, 1);
    tick();
    rd_take = 0;
    #1 chk("r23_miss", rd_hit, 0);
    chk("r23_occ", occupancy, 2);
    tick();
    quiet();
    ins(8'h15, 16'h0715, 0);
    chk("r23_occ2", occupancy, 3);

    hard_reset();
    for (int i = 0; i < 3; i++) ins(AW'(8'h60 + i), DW'(16'h600 + i), 1);
    wb_ready = 0;
    flush_req = 1;
    tick();
    quiet();
    repeat (4) tick();
    chk("r24_busy", flush_busy, 1);
    chk("r24_stall", wb_valid, 1);
    wb_ready = 1;
    beats = 0;
    for (int k = 0; k < 40 && flush_busy; k++) begin
      if (wb_valid) beats++;
      tick();
    end
    chk("r24_done", flush_busy, 0);
    chk("r24_beats", beats, 3);
    chk("r24_occ", occupancy, 0);

    hard_reset();
    for (int c = 0; c < 4000; c++) begin
      rst       = (mst == 1) && ($urandom_range(0, 15) == 0);
      rd_valid  = $urandom_range(0, 1);
      rd_addr   = AW'(8'h60 + $urandom_range(0, 7));
      rd_take   = ($urandom_range(0, 3) == 0);
      ins_valid = $urandom_range(0, 1);
      ins_addr  = AW'(8'h60 + $urandom_range(0, 7));
      ins_data  = DW'($urandom);
      ins_dirty = $urandom_range(0, 1);
      wb_ready  = ($urandom_range(0, 9) < 6);
      flush_req = ($urandom_range(0, 49) == 0);
      tick();
    end
    quiet();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
